// File: rtl/tt_um_walk_check.sv
// Walking-one checker: follows 0x01,0x02..0x80,0x00 on ui_in, counts accepted
// steps, and flags a bad step or a value held longer than MAX_HOLD evaluations.
module tt_um_walk_check #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_TRACK = 2'b01,
    S_DONE  = 2'b10,
    S_FAIL  = 2'b11
  } state_e;

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_e     state_q, state_d;
  logic [7:0] in_q;
  logic [7:0] cur_q, cur_d;
  logic [3:0] step_q, step_d;
  logic [3:0] hold_q, hold_d;
  logic [1:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic       fail_q, fail_d;

  logic       clear;
  logic       unused_uio_bits;

  assign clear           = uio_in[7];
  assign unused_uio_bits = &{1'b0, uio_in[6:0]};

  // Input stage keeps sampling even while ena is low or clear is asserted.
  // NOTE: sequential state uses <= so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_q <= 8'h00;
    else        in_q <= ui_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cur_q   <= 8'h00;
      step_q  <= 4'd0;
      hold_q  <= 4'd0;
      err_q   <= ERR_NONE;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first so no path can infer a latch.
    state_d = state_q;
    cur_d   = cur_q;
    step_d  = step_q;
    hold_d  = hold_q;
    err_d   = err_q;
    pass_d  = pass_q;
    fail_d  = fail_q;

    if (clear) begin
      state_d = S_IDLE;
      cur_d   = 8'h00;
      step_d  = 4'd0;
      hold_d  = 4'd0;
      err_d   = ERR_NONE;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
    end else if (ena) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (in_q == 8'h01) begin
            state_d = S_TRACK;
            cur_d   = 8'h01;
            hold_d  = 4'd1;
            step_d  = 4'd0;
            pass_d  = 1'b0;
          end
        end
        S_TRACK: begin
          if (in_q == cur_q) begin
            if (hold_q == MAX_HOLD_C) begin
              state_d = S_FAIL;
              err_d   = ERR_TIMEOUT;
              fail_d  = 1'b1;
            end else begin
              hold_d = hold_q + 4'd1;
            end
          end else if (in_q == {cur_q[6:0], 1'b0} && in_q != 8'h00) begin
            cur_d  = in_q;
            step_d = step_q + 4'd1;
            hold_d = 4'd1;
          end else if (in_q == 8'h00 && cur_q == 8'h80) begin
            state_d = S_DONE;
            step_d  = 4'd8;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
            err_d   = ERR_BAD;
            fail_d  = 1'b1;
          end
        end
        S_FAIL: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign uo_out  = {state_q, fail_q, pass_q, step_q};
  assign uio_out = {6'b000000, err_q};
  assign uio_oe  = 8'h7F;

endmodule

// File: tb/tb_tt_um_walk_check.sv
// Directed bench for tt_um_walk_check: inputs change and outputs are checked
// on the falling edge, midway between the active rising edges.
module tb_tt_um_walk_check;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] uo_out;

  int checks   = 0;
  int failures = 0;

  tt_um_walk_check #(.MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .uo_out (uo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] v);
    @(negedge clk);
    ui_in = v;
  endtask

  task automatic do_clear();
    @(negedge clk);
    ui_in  = 8'h00;
    uio_in = 8'h80;
    @(negedge clk);
    uio_in = 8'h00;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    cyc(3);
    checks++;
    if (uo_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_uo_out got=%h exp=%h", uo_out, 8'h00);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_uio_out got=%h exp=%h", uio_out, 8'h00);
    end
    checks++;
    if (uio_oe !== 8'h7F) begin
      failures++;
      $display("FAIL reset_uio_oe got=%h exp=%h", uio_oe, 8'h7F);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) apply(8'h01 << i);
    apply(8'h00);
    cyc(2);
    checks++;
    if (uo_out !== 8'h98) begin
      failures++;
      $display("FAIL sweep_uo_out got=%h exp=%h", uo_out, 8'h98);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      failures++;
      $display("FAIL sweep_uio_out got=%h exp=%h", uio_out, 8'h00);
    end
    cyc(10);
    checks++;
    if (uo_out !== 8'h98) begin
      failures++;
      $display("FAIL done_no_timeout got=%h exp=%h", uo_out, 8'h98);
    end
    apply(8'h01);
    cyc(2);
    checks++;
    if (uo_out !== 8'h40) begin
      failures++;
      $display("FAIL done_restart got=%h exp=%h", uo_out, 8'h40);
    end
  endtask

  task automatic test_bad_step();
    do_clear();
    apply(8'h01);
    apply(8'h02);
    apply(8'h08);
    cyc(2);
    checks++;
    if (uo_out !== 8'hE1) begin
      failures++;
      $display("FAIL bad_step_uo_out got=%h exp=%h", uo_out, 8'hE1);
    end
    checks++;
    if (uio_out !== 8'h01) begin
      failures++;
      $display("FAIL bad_step_uio_out got=%h exp=%h", uio_out, 8'h01);
    end
    apply(8'h01);
    cyc(4);
    checks++;
    if (uo_out !== 8'hE1) begin
      failures++;
      $display("FAIL fail_sticky got=%h exp=%h", uo_out, 8'hE1);
    end
  endtask

  task automatic test_timeout();
    do_clear();
    apply(8'h01);
    cyc(3);
    apply(8'h02);
    cyc(2);
    checks++;
    if (uo_out !== 8'h41) begin
      failures++;
      $display("FAIL hold4_accept got=%h exp=%h", uo_out, 8'h41);
    end
    cyc(3);
    checks++;
    if (uo_out !== 8'h41) begin
      failures++;
      $display("FAIL hold_at_limit got=%h exp=%h", uo_out, 8'h41);
    end
    ui_in = 8'h00;
    cyc(1);
    checks++;
    if (uo_out !== 8'hE1) begin
      failures++;
      $display("FAIL timeout_uo_out got=%h exp=%h", uo_out, 8'hE1);
    end
    checks++;
    if (uio_out !== 8'h02) begin
      failures++;
      $display("FAIL timeout_uio_out got=%h exp=%h", uio_out, 8'h02);
    end
  endtask

  task automatic test_clear();
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h80;
    cyc(1);
    checks++;
    if (uo_out !== 8'h00) begin
      failures++;
      $display("FAIL clear_uo_out got=%h exp=%h", uo_out, 8'h00);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      failures++;
      $display("FAIL clear_uio_out got=%h exp=%h", uio_out, 8'h00);
    end
    uio_in = 8'h00;
    ena    = 1'b1;
    apply(8'h01);
    cyc(2);
    checks++;
    if (uo_out !== 8'h40) begin
      failures++;
      $display("FAIL clear_reenter got=%h exp=%h", uo_out, 8'h40);
    end
  endtask

  task automatic test_ena_gating();
    do_clear();
    apply(8'h01);
    apply(8'h02);
    apply(8'h04);
    cyc(2);
    checks++;
    if (uo_out !== 8'h42) begin
      failures++;
      $display("FAIL ena_pre got=%h exp=%h", uo_out, 8'h42);
    end
    ena = 1'b0;
    cyc(10);
    checks++;
    if (uo_out !== 8'h42) begin
      failures++;
      $display("FAIL ena_frozen got=%h exp=%h", uo_out, 8'h42);
    end
    ena = 1'b1;
    ui_in = 8'h08;
    for (int i = 4; i < 8; i++) apply(8'h01 << i);
    apply(8'h00);
    cyc(2);
    checks++;
    if (uo_out !== 8'h98) begin
      failures++;
      $display("FAIL ena_done got=%h exp=%h", uo_out, 8'h98);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    apply(8'h01);
    apply(8'h02);
    cyc(2);
    checks++;
    if (uo_out !== 8'h41) begin
      failures++;
      $display("FAIL pre_reset_track got=%h exp=%h", uo_out, 8'h41);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_uo_out got=%h exp=%h", uo_out, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply(8'h10);
    apply(8'h20);
    cyc(3);
    checks++;
    if (uo_out !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_idle got=%h exp=%h", uo_out, 8'h00);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      failures++;
      $display("FAIL post_reset_uio_out got=%h exp=%h", uio_out, 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_bad_step();
    test_timeout();
    test_clear();
    test_ena_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_walk_check.md
# tt_um_walk_check

Hardware checker for the walking-one stimulus our benches drive onto `ui_in`: the sequence 0x01, 0x02, 0x04 … 0x80, 0x00.
- Tracks each step and counts accepted steps.
- Flags a bad step or a stalled input.
- Reports pass/fail status on `uo_out` and an error code on `uio_out`.

It is a TinyTapeout user module, so a silicon copy can check a generator on another tile or on the board.

## Interface
- `MAX_HOLD`, default 4: maximum number of consecutive evaluated cycles one value may stay on the input during tracking. Legal range 1..15.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design selected. While low, the FSM and counters freeze; the input register keeps sampling.
- `ui_in`  in  8  pattern under test.
- `uio_in`  in  8  bit 7 = synchronous clear, active high. Bits 6:0 are ignored.
- `uio_out`  out  8  [1:0] error code (00 none, 01 bad step, 10 timeout), [7:2] = 0.
- `uio_oe`  out  8  constant 8'h7F.
- `uo_out`  out  8  {state[1:0], fail, pass, step_cnt[3:0]}.

## Operation
- `in_q`: 8-bit register that captures `ui_in` on every clock edge. All comparisons use `in_q`, never `ui_in` directly.
- Registers: `cur` (8 b), `step_cnt` (4 b), `hold_cnt` (4 b), `err` (2 b), `pass`, `fail`.
- State encoding: IDLE=00, TRACK=01, DONE=10, FAIL=11.
- Priority, highest first:
  - `rst_n`.
  - `uio_in[7]` (clear; acts regardless of `ena`): go to IDLE with all registers zeroed.
  - `ena`=0: hold everything.
  - FSM.
- IDLE:
  - If `in_q`==0x01: go to TRACK with `cur`=0x01, `hold_cnt`=1, `step_cnt`=0.
  - Any other value is ignored.
- TRACK, when `in_q`==`cur`:
  - If `hold_cnt`==`MAX_HOLD`: go to FAIL with `err`=10 and `fail`=1.
  - Else `hold_cnt`++.
- TRACK, when `in_q`!=`cur`:
  - If `in_q`=={`cur`[6:0],1'b0} and `in_q`!=0: accept the step. Set `cur`=`in_q`, `step_cnt`++, `hold_cnt`=1.
  - If `in_q`==0 and `cur`==0x80: go to DONE with `step_cnt`=8 and `pass`=1.
  - Otherwise: go to FAIL with `err`=01 and `fail`=1.
- DONE:
  - No timeout.
  - If `in_q`==0x01: go to TRACK as from IDLE, clearing `pass` and `step_cnt`.
- FAIL:
  - Sticky until clear or reset.
  - `step_cnt` freezes at the number of steps accepted before the failure.
- Arithmetic: `step_cnt` reaches at most 8 and never wraps. `hold_cnt` never exceeds `MAX_HOLD`.

## Timing
- Reset values:
  - `uo_out`=0x00, `uio_out`=0x00, `uio_oe`=0x7F.
  - State IDLE, all registers 0.
  - Outputs change as soon as `rst_n` falls, without waiting for a clock edge.
- Latency: a `ui_in` value present at edge N is in `in_q` after edge N. The FSM acts on it at edge N+1, so outputs reflect it after edge N+1 (2 edges).
- All outputs are registered or constant. There is no combinational path from any input to any output.
- Clear: `uio_in[7]` is sampled at edge N and the outputs read 0x00 after edge N. Clear is 1 edge faster than data because it bypasses `in_q`.
- `ena` low: `hold_cnt` does not advance, so no timeout can occur. On return, the first evaluation uses the current `in_q`.
- Reset mid-TRACK: returns to IDLE. A following non-0x01 value (e.g. 0x10) is ignored.

## Test plan
- Full sweep, `MAX_HOLD`=4, one new value per clock: 0x01, 0x02 … 0x80, 0x00 -> `uo_out`=0x98 (DONE, pass, step 8), `uio_out`=0x00.
- Bad step: 0x01, 0x02, 0x08 -> `uo_out`=0xE1 (FAIL, fail, step 1), `uio_out`=0x01.
- Timeout:
  - 0x01 held for 4 evaluations then 0x02 -> remains TRACK.
  - 0x02 held for 5 evaluations -> `uo_out`=0xE1, `uio_out`=0x02.
- Clear: from FAIL, pulse `uio_in[7]` for one cycle -> `uo_out`=0x00 and `uio_out`=0x00 after that edge. A new 0x01 then re-enters TRACK.
- Enable gating: in TRACK at 0x04, drop `ena` for 10 cycles with the value held, then raise it and continue 0x08 … 0x00 -> no timeout, DONE, `uo_out`=0x98.
- Async reset: assert `rst_n`=0 between edges mid-TRACK -> `uo_out` reads 0x00 immediately. After release, drive 0x10, 0x20 -> stays IDLE, `uo_out`=0x00.
